// File: rtl/response_monitor_array_pkg.sv
// response_pkg: definitions shared by the response monitor array.
//   ch_state_t - per-channel obligation state (IDLE / PENDING / VIOLATED)
//   cnt_width  - counter width needed to count up to a given deadline
package response_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    VIOLATED = 2'd2
  } ch_state_t;

  // Width of a counter able to hold values 0..deadline (never below 1 bit).
  function automatic int cnt_width(input int deadline);
    int w;
    w = $clog2(deadline + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/response_monitor_array_channel.sv
// response_channel: one response-property monitor, G(A -> F B), optionally
// with a deadline of DEADLINE run cycles after the triggering A.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   run             - trace-step enable
//   clr             - synchronous clear (priority over run)
//   a, b            - trigger / response propositions
//   report          - registered: channel is IDLE
//   violated        - registered: channel is VIOLATED (sticky)
//   report_next     - state that report takes on the coming edge
//   violated_next   - state that violated takes on the coming edge
module response_channel
  import response_pkg::*;
#(
  parameter int BOUNDED  = 0,
  parameter int DEADLINE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  input  logic a,
  input  logic b,
  output logic report,
  output logic violated,
  output logic report_next,
  output logic violated_next
);

  localparam int CW = cnt_width(DEADLINE);
  // Counter value seen on the last run cycle that may still carry the response.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEADLINE - 1);
  localparam logic [CW-1:0] MAX_CNT  = {CW{1'b1}};
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  ch_state_t       state_r;
  ch_state_t       state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic            report_r;
  logic            violated_r;

  // Next-state and counter logic for one channel.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (clr) begin
      state_s = IDLE;
      cnt_s   = ZERO_CNT;
    end else if (run) begin
      case (state_r)
        IDLE: begin
          // A together with B discharges itself in the same step.
          if (a && !b) begin
            state_s = PENDING;
            cnt_s   = ZERO_CNT;
          end else begin
            state_s = IDLE;
            cnt_s   = ZERO_CNT;
          end
        end
        PENDING: begin
          // A re-asserted here is ignored: the oldest obligation governs.
          if (b) begin
            state_s = IDLE;
            cnt_s   = ZERO_CNT;
          end else if ((BOUNDED != 0) && (cnt_r == LAST_CNT)) begin
            state_s = VIOLATED;
            cnt_s   = cnt_r;
          end else if (cnt_r != MAX_CNT) begin
            state_s = PENDING;
            cnt_s   = cnt_r + CW'(1'b1);
          end else begin
            state_s = PENDING;
            cnt_s   = cnt_r;
          end
        end
        VIOLATED: begin
          state_s = VIOLATED;
          cnt_s   = cnt_r;
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          state_s = IDLE;
          cnt_s   = ZERO_CNT;
        end
      endcase
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  // State, counter and registered flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= ZERO_CNT;
      report_r   <= 1'b1;
      violated_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      report_r   <= (state_s == IDLE);
      violated_r <= (state_s == VIOLATED);
    end
  end

  assign report        = report_r;
  assign violated      = violated_r;
  assign report_next   = (state_s == IDLE);
  assign violated_next = (state_s == VIOLATED);

endmodule

// File: rtl/response_monitor_array.sv
// response_monitor_array: CH independent response monitors plus registered
// aggregate flags.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   run           - trace-step enable
//   clr           - synchronous clear of every channel (priority over run)
//   A, B [CH]     - per-channel trigger / response propositions
//   report [CH]   - registered: channel is IDLE
//   violated [CH] - registered: channel is VIOLATED (sticky)
//   all_report    - registered AND of report
//   any_violated  - registered OR of violated
module response_monitor_array
  import response_pkg::*;
#(
  parameter int CH       = 4,
  parameter int BOUNDED  = 0,
  parameter int DEADLINE = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clr,
  input  logic [CH-1:0] A,
  input  logic [CH-1:0] B,
  output logic [CH-1:0] report,
  output logic [CH-1:0] violated,
  output logic          all_report,
  output logic          any_violated
);

  logic [CH-1:0] report_next_s;
  logic [CH-1:0] violated_next_s;
  logic          all_report_r;
  logic          any_violated_r;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    response_channel #(
      .BOUNDED  (BOUNDED),
      .DEADLINE (DEADLINE)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .clr           (clr),
      .a             (A[i]),
      .b             (B[i]),
      .report        (report[i]),
      .violated      (violated[i]),
      .report_next   (report_next_s[i]),
      .violated_next (violated_next_s[i])
    );
  end

  // Aggregates are built from next-state flags so they align with report/violated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      all_report_r   <= 1'b1;
      any_violated_r <= 1'b0;
    end else begin
      all_report_r   <= &report_next_s;
      any_violated_r <= |violated_next_s;
    end
  end

  assign all_report   = all_report_r;
  assign any_violated = any_violated_r;

endmodule

// File: tb/tb_response_monitor_array.sv
// Testbench for response_monitor_array: three instances (bounded CH=4 D=3,
// unbounded CH=1, bounded CH=1 D=2) sharing clock, reset, run and clr.
module tb_response_monitor_array;

  logic       clk;
  logic       rst;
  logic       run;
  logic       clr;
  logic [3:0] a_b, b_b;
  logic [3:0] rep_b, vio_b;
  logic       all_b, any_b;
  logic [0:0] a_u, b_u, rep_u, vio_u;
  logic       all_u, any_u;
  logic [0:0] a_2, b_2, rep_2, vio_2;
  logic       all_2, any_2;

  int total;
  int bad;

  typedef struct {
    logic       run;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] rep;
    logic [3:0] vio;
    logic       all;
    logic       any;
  } vec_t;

  vec_t tbl [11];

  response_monitor_array #(.CH(4), .BOUNDED(1), .DEADLINE(3)) dut_b (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .A(a_b), .B(b_b),
    .report(rep_b), .violated(vio_b), .all_report(all_b), .any_violated(any_b)
  );

  response_monitor_array #(.CH(1), .BOUNDED(0), .DEADLINE(8)) dut_u (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .A(a_u), .B(b_u),
    .report(rep_u), .violated(vio_u), .all_report(all_u), .any_violated(any_u)
  );

  response_monitor_array #(.CH(1), .BOUNDED(1), .DEADLINE(2)) dut_2 (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .A(a_2), .B(b_2),
    .report(rep_2), .violated(vio_2), .all_report(all_2), .any_violated(any_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_ab();
    a_b = 4'd0; b_b = 4'd0; a_u = 1'b0; b_u = 1'b0; a_2 = 1'b0; b_2 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; run = 1'b0; clr = 1'b0;
    zero_ab();

    //              run   clr   a      b      rep    vio    all   any
    tbl[0]  = '{1'b1, 1'b0, 4'h7, 4'h2, 4'hA, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'h5, 4'h0, 4'hA, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, 4'hF, 4'hA, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'h1, 4'h0, 4'hA, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'h4, 4'hE, 4'h1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 4'h4, 4'h1, 4'hA, 4'h1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hA, 4'h1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'h8, 4'h0, 4'h7, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'h2, 4'h0, 4'hD, 4'h0, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_report", {28'd0, rep_b}, 32'hF);
    chk("rst_violated", {28'd0, vio_b}, 32'h0);
    chk("rst_all", {31'd0, all_b}, 32'd1);
    chk("rst_any", {31'd0, any_b}, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven sequence on the bounded 4-channel instance
    for (int i = 0; i < 11; i++) begin
      run = tbl[i].run; clr = tbl[i].clr; a_b = tbl[i].a; b_b = tbl[i].b;
      tick();
      chk($sformatf("vec%0d_report", i), {28'd0, rep_b}, {28'd0, tbl[i].rep});
      chk($sformatf("vec%0d_violated", i), {28'd0, vio_b}, {28'd0, tbl[i].vio});
      chk($sformatf("vec%0d_all", i), {31'd0, all_b}, {31'd0, tbl[i].all});
      chk($sformatf("vec%0d_any", i), {31'd0, any_b}, {31'd0, tbl[i].any});
    end
    clr = 1'b1; run = 1'b0; zero_ab();
    tick();
    clr = 1'b0;

    // Unbounded: open obligation for 20 idle steps, then discharge
    run = 1'b1; a_u = 1'b1; b_u = 1'b0;
    tick();
    chk("unb_step0_report", {31'd0, rep_u}, 32'd0);
    a_u = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      tick();
      chk($sformatf("unb_step%0d_report", s), {31'd0, rep_u}, 32'd0);
    end
    chk("unb_violated", {31'd0, vio_u}, 32'd0);
    chk("unb_any", {31'd0, any_u}, 32'd0);
    b_u = 1'b1;
    tick();
    chk("unb_step21_report", {31'd0, rep_u}, 32'd1);
    chk("unb_step21_all", {31'd0, all_u}, 32'd1);
    b_u = 1'b0;

    // Deadline 2: run=0 freezes the counter
    a_2 = 1'b1;
    tick();
    chk("d2_pending", {31'd0, rep_2}, 32'd0);
    a_2 = 1'b0; run = 1'b0;
    for (int s = 0; s < 10; s++) begin
      tick();
    end
    chk("d2_hold_report", {31'd0, rep_2}, 32'd0);
    chk("d2_hold_violated", {31'd0, vio_2}, 32'd0);
    run = 1'b1;
    tick();
    chk("d2_step1_violated", {31'd0, vio_2}, 32'd0);
    tick();
    chk("d2_step2_violated", {31'd0, vio_2}, 32'd1);
    chk("d2_step2_any", {31'd0, any_2}, 32'd1);
    b_2 = 1'b1;
    tick();
    chk("d2_sticky", {31'd0, vio_2}, 32'd1);
    b_2 = 1'b0; clr = 1'b1;
    tick();
    chk("d2_clr_report", {31'd0, rep_2}, 32'd1);
    chk("d2_clr_violated", {31'd0, vio_2}, 32'd0);
    clr = 1'b0;

    // Mid-cycle async reset discards pending/violated state
    a_b = 4'h5;
    tick();
    a_b = 4'h0;
    tick(); tick(); tick();
    chk("pre_rst_violated", {28'd0, vio_b}, 32'h5);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_report", {28'd0, rep_b}, 32'hF);
    chk("async_rst_violated", {28'd0, vio_b}, 32'h0);
    chk("async_rst_all", {31'd0, all_b}, 32'd1);
    chk("async_rst_any", {31'd0, any_b}, 32'd0);
    tick();
    rst = 1'b0;

    // First run cycle after release is step 0; violation lands after step 3
    a_b = 4'h1;
    tick();
    a_b = 4'h0;
    tick(); tick();
    chk("post_rst_step2_violated", {28'd0, vio_b}, 32'h0);
    tick();
    chk("post_rst_step3_violated", {28'd0, vio_b}, 32'h1);
    chk("post_rst_step3_report", {28'd0, rep_b}, 32'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
